// File: rtl/if_stage_fetch.sv
// rtl/if_stage_fetch.sv - Instruction-fetch stage: PC, imem req/ack handshake, IF/ID register.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [63:0] ifid_reg,
    output logic        ifid_valid,
    output logic [31:0] fetch_pc
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_DROP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [63:0] ifid_q, ifid_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] target_pc;

    assign pc_plus4  = pc_q + 32'd4;
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        hold_instr_d = hold_instr_q;
        ifid_d       = ifid_q;
        valid_d      = valid_q;

        case (state_q)
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = target_pc;
                    end else if (!flush) begin
                        if (stall) begin
                            hold_instr_d = imem_rdata;
                            state_d      = ST_HOLD;
                        end else begin
                            ifid_d  = {pc_plus4, imem_rdata};
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end
                    end
                end else if (redirect) begin
                    // Outstanding request must keep its address; remember the target instead.
                    pend_pc_d = target_pc;
                    state_d   = ST_DROP;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pend_pc_d = target_pc;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? target_pc : pend_pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = target_pc;
                    state_d = ST_REQ;
                end else if (!flush && !stall) begin
                    ifid_d  = {pc_plus4, hold_instr_q};
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        if (flush) begin
            ifid_d  = {32'h0, NOP_INSTR};
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            ifid_q       <= {32'h0, NOP_INSTR};
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            ifid_q       <= ifid_d;
            valid_q      <= valid_d;
        end
    end

    // In DROP the PC has not moved yet, so it still names the outstanding request.
    assign imem_req   = (state_q != ST_HOLD);
    assign imem_addr  = pc_q & 32'hFFFF_FFFC;
    assign ifid_reg   = ifid_q;
    assign ifid_valid = valid_q;
    assign fetch_pc   = pc_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// tb/tb_if_stage_fetch.sv - Scoreboard testbench for if_stage_fetch.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [63:0] ifid_reg;
    logic        ifid_valid;
    logic [31:0] fetch_pc;

    logic        ack_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic [63:0] prev_ifid = 64'h0;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign imem_ack   = ack_en;
    assign imem_rdata = instr_at(imem_addr);

    always #5 clk = ~clk;

    if_stage_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_reg    (ifid_reg),
        .ifid_valid  (ifid_valid),
        .fetch_pc    (fetch_pc)
    );

    // Every newly loaded valid IF/ID word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (ifid_valid && (!prev_valid || ifid_reg !== prev_ifid)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ifid_unexpected got %h expected none", ifid_reg);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (ifid_reg !== e) begin
                        errors++;
                        $display("FAIL ifid_scoreboard got %h expected %h", ifid_reg, e);
                    end
                end
            end
            prev_valid = ifid_valid;
            prev_ifid  = ifid_reg;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        ack_en = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        ack_en = 1'b1; redirect = 1'b1; redirect_pc = a;
        @(negedge clk);
        ack_en = 1'b0; redirect = 1'b0;
    endtask

    task automatic expect_drained(input string name);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got %0d pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_bubble_state(input string name);
        checks++;
        if (ifid_reg !== 64'h0 || ifid_valid !== 1'b0 || fetch_pc !== 32'h0 ||
            imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL %s got ifid=%h v=%b pc=%h req=%b addr=%h expected 0/0/0/1/0",
                     name, ifid_reg, ifid_valid, fetch_pc, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_bubble_state("reset_state");
    endtask

    task automatic test_zero_wait();
        do_reset();
        ack_en = 1'b1;
        exp_q.push_back({32'h4, instr_at(32'h0)});
        exp_q.push_back({32'h8, instr_at(32'h4)});
        exp_q.push_back({32'hC, instr_at(32'h8)});
        repeat (3) @(negedge clk);
        ack_en = 1'b0;
        checks++;
        if (fetch_pc !== 32'hC) begin
            errors++;
            $display("FAIL zero_wait_pc got %h expected 0000000c", fetch_pc);
        end
        expect_drained("zero_wait");
    endtask

    task automatic test_wait_states();
        do_reset();
        goto_pc(32'h10);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL wait_addr_hold cyc%0d got addr=%h req=%b expected 00000010/1",
                         i, imem_addr, imem_req);
            end
            @(negedge clk);
        end
        ack_en = 1'b1;
        exp_q.push_back({32'h14, instr_at(32'h10)});
        @(negedge clk);
        ack_en = 1'b0;
        checks++;
        if (imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL wait_next_addr got %h expected 00000014", imem_addr);
        end
        expect_drained("wait_states");
    endtask

    task automatic test_stall();
        do_reset();
        goto_pc(32'h1C);
        ack_en = 1'b1;
        exp_q.push_back({32'h20, instr_at(32'h1C)});
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || ifid_reg !== {32'h20, instr_at(32'h1C)} || ifid_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cyc%0d got req=%b ifid=%h v=%b expected 0/%h/1",
                         i, imem_req, ifid_reg, ifid_valid, {32'h20, instr_at(32'h1C)});
            end
        end
        stall = 1'b0; ack_en = 1'b0;
        exp_q.push_back({32'h24, instr_at(32'h20)});
        @(negedge clk);
        checks++;
        if (fetch_pc !== 32'h24 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got pc=%h req=%b expected 00000024/1", fetch_pc, imem_req);
        end
        expect_drained("stall");
    endtask

    task automatic test_redirect_pending();
        do_reset();
        goto_pc(32'h30);
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        redirect_pc = 32'h403;
        @(negedge clk);
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 32'h30 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL drop_addr_hold got addr=%h req=%b expected 00000030/1", imem_addr, imem_req);
        end
        ack_en = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h400 || ifid_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_target got addr=%h v=%b expected 00000400/0", imem_addr, ifid_valid);
        end
        exp_q.push_back({32'h404, instr_at(32'h400)});
        @(negedge clk);
        ack_en = 1'b0;
        expect_drained("redirect_pending");
    endtask

    task automatic test_flush_redirect_stall();
        do_reset();
        goto_pc(32'h40);
        ack_en = 1'b1;
        exp_q.push_back({32'h44, instr_at(32'h40)});
        @(negedge clk);
        stall = 1'b1; flush = 1'b1; redirect = 1'b1; redirect_pc = 32'h600;
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        checks++;
        if (ifid_reg !== 64'h0 || ifid_valid !== 1'b0 || fetch_pc !== 32'h600) begin
            errors++;
            $display("FAIL flush_redirect got ifid=%h v=%b pc=%h expected 0/0/00000600",
                     ifid_reg, ifid_valid, fetch_pc);
        end
        exp_q.push_back({32'h604, instr_at(32'h600)});
        @(negedge clk);
        ack_en = 1'b0;
        expect_drained("flush_redirect");
    endtask

    task automatic test_wrap_and_reset_in_drop();
        do_reset();
        goto_pc(32'hFFFF_FFFC);
        ack_en = 1'b1;
        exp_q.push_back({32'h0, instr_at(32'hFFFF_FFFC)});
        @(negedge clk);
        ack_en = 1'b0;
        checks++;
        if (imem_addr !== 32'h0 || ifid_reg[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL wrap got addr=%h pc4=%h expected 0/0", imem_addr, ifid_reg[63:32]);
        end
        redirect = 1'b1; redirect_pc = 32'h800;
        @(negedge clk);
        redirect = 1'b0;
        expect_drained("wrap");
        #2 rst = 1'b1;
        #1 check_bubble_state("reset_in_drop");
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        ack_en = 1'b1;
        exp_q.push_back({32'h4, instr_at(32'h0)});
        @(negedge clk);
        ack_en = 1'b0;
        expect_drained("after_reset");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_flush_redirect_stall();
        test_wrap_and_reset_in_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
